// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, one-cycle lookup and mispredict statistics
module branch_predictor #(
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        lk_valid,
  input  logic [31:0] lk_pc,
  input  logic        lk_stall,
  output logic        pr_valid,
  output logic        pr_taken,
  output logic [31:0] pr_target,
  input  logic        up_valid,
  input  logic [31:0] up_pc,
  input  logic        up_is_br,
  input  logic        up_taken,
  input  logic [31:0] up_target,
  input  logic        up_mispredict,
  input  logic        flush_all,
  output logic [31:0] stat_mispredicts
);
  localparam int N  = 1 << IDX_W;
  localparam int TW = 30 - IDX_W;
  logic [N-1:0]     vld;
  logic [TW-1:0]    tag_q [N];
  logic [31:0]      tgt_q [N];
  logic [1:0]       ctr_q [N];
  logic [IDX_W-1:0] lk_idx, up_idx;
  logic             lk_hit, up_hit, up_br;
  logic [1:0]       ctr_inc, ctr_dec;
  logic             unused_pc_bits;
  assign unused_pc_bits = ^{lk_pc[1:0], up_pc[1:0]};
  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign up_idx  = up_pc[IDX_W+1:2];
  assign lk_hit  = vld[lk_idx] && tag_q[lk_idx] == lk_pc[31:IDX_W+2];
  assign up_hit  = vld[up_idx] && tag_q[up_idx] == up_pc[31:IDX_W+2];
  assign up_br   = up_valid & up_is_br;
  assign ctr_inc = &ctr_q[up_idx] ? 2'b11 : ctr_q[up_idx] + 2'd1;
  assign ctr_dec = ~|ctr_q[up_idx] ? 2'b00 : ctr_q[up_idx] - 2'd1;
  // prediction register: reads pre-update table contents, frozen while fetch stalls
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pr_valid  <= 1'b0;
      pr_taken  <= 1'b0;
      pr_target <= '0;
    end else if (!lk_stall) begin
      pr_valid  <= lk_valid;
      pr_taken  <= lk_valid & lk_hit & ctr_q[lk_idx][1];
      pr_target <= lk_hit ? tgt_q[lk_idx] : '0;
    end
  end
  // valid bits and counters; flush wins over a same-cycle update
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld <= '0;
      for (int i = 0; i < N; i++) ctr_q[i] <= 2'b01;
    end else if (flush_all) begin
      vld <= '0;
    end else if (up_br) begin
      if (up_hit) begin
        ctr_q[up_idx] <= up_taken ? ctr_inc : ctr_dec;
      end else if (up_taken) begin
        vld[up_idx]   <= 1'b1;
        ctr_q[up_idx] <= 2'b10;
      end
    end
  end
  // tags and targets need no reset: an entry is only used once its valid bit is set
  always_ff @(posedge clk) begin
    if (up_br & up_taken & ~flush_all) begin
      tgt_q[up_idx] <= up_target;
      if (!up_hit) tag_q[up_idx] <= up_pc[31:IDX_W+2];
    end
  end
  // saturating mispredict counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) stat_mispredicts <= '0;
    else if (up_valid & up_mispredict & ~&stat_mispredicts) stat_mispredicts <= stat_mispredicts + 32'd1;
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: random and directed checks of branch_predictor against a behavioural BTB model
module tb_branch_predictor;
  localparam int IDX_W = 4;
  localparam int N = 1 << IDX_W;
  logic clk = 0, resetn = 0;
  logic lk_valid = 0, lk_stall = 0, up_valid = 0, up_is_br = 0, up_taken = 0, up_mispredict = 0, flush_all = 0;
  logic [31:0] lk_pc = 0, up_pc = 0, up_target = 0;
  logic pr_valid, pr_taken;
  logic [31:0] pr_target, stat_mispredicts;
  int total = 0, bad = 0;
  logic run = 0, stat_forced = 0;
  bit m_valid [N];
  int m_ctr [N];
  logic [31:0] m_pc [N], m_tgt [N];
  logic e_valid, e_taken;
  logic [31:0] e_target, e_stat;

  branch_predictor #(.IDX_W(IDX_W)) dut (
    .clk(clk), .resetn(resetn), .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_stall(lk_stall),
    .pr_valid(pr_valid), .pr_taken(pr_taken), .pr_target(pr_target),
    .up_valid(up_valid), .up_pc(up_pc), .up_is_br(up_is_br), .up_taken(up_taken),
    .up_target(up_target), .up_mispredict(up_mispredict), .flush_all(flush_all),
    .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  function automatic int idx(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx(pc)] && (m_pc[idx(pc)] >> (IDX_W + 2)) == (pc >> (IDX_W + 2));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: lookup sees the table as it was before this edge's update/flush
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i] <= 0;
        m_ctr[i] <= 1;
      end
      e_valid <= 0;
      e_taken <= 0;
      e_target <= 0;
      e_stat <= 0;
    end else begin
      if (!lk_stall) begin
        e_valid <= lk_valid;
        e_taken <= lk_valid && m_hit(lk_pc) && m_ctr[idx(lk_pc)] >= 2;
        e_target <= m_hit(lk_pc) ? m_tgt[idx(lk_pc)] : 32'h0;
      end
      if (flush_all) begin
        for (int i = 0; i < N; i++) m_valid[i] <= 0;
      end else if (up_valid && up_is_br) begin
        if (m_hit(up_pc)) begin
          if (up_taken) begin
            m_ctr[idx(up_pc)] <= (m_ctr[idx(up_pc)] + 1 > 3) ? 3 : m_ctr[idx(up_pc)] + 1;
            m_tgt[idx(up_pc)] <= up_target;
          end else begin
            m_ctr[idx(up_pc)] <= (m_ctr[idx(up_pc)] - 1 < 0) ? 0 : m_ctr[idx(up_pc)] - 1;
          end
        end else if (up_taken) begin
          m_valid[idx(up_pc)] <= 1;
          m_pc[idx(up_pc)] <= up_pc;
          m_tgt[idx(up_pc)] <= up_target;
          m_ctr[idx(up_pc)] <= 2;
        end
      end
      if (up_valid && up_mispredict && e_stat != 32'hFFFFFFFF) e_stat <= e_stat + 1;
    end
  end

  // compare DUT against model mid-cycle
  always @(negedge clk) begin
    if (run) begin
      chk("pr_valid", {31'd0, pr_valid}, {31'd0, e_valid});
      chk("pr_taken", {31'd0, pr_taken}, {31'd0, e_taken});
      chk("pr_target", pr_target, e_target);
      if (!stat_forced) chk("stat", stat_mispredicts, e_stat);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    lk_valid = 0; lk_stall = 0; up_valid = 0; up_is_br = 0;
    up_taken = 0; up_mispredict = 0; flush_all = 0;
  endtask

  task automatic lk(input logic [31:0] pc);
    lk_valid = 1; lk_pc = pc;
  endtask

  task automatic up(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    up_valid = 1; up_is_br = 1; up_pc = pc; up_taken = tk; up_target = tgt;
  endtask

  initial begin
    tick();
    run = 1;
    chk("rst_valid", {31'd0, pr_valid}, 0);
    chk("rst_stat", stat_mispredicts, 0);
    resetn = 1;
    lk(32'hBFC00010); tick();
    chk("cold_valid", {31'd0, pr_valid}, 1);
    chk("cold_taken", {31'd0, pr_taken}, 0);
    chk("cold_target", pr_target, 0);
    up(32'hBFC00010, 1, 32'hBFC00100); tick();
    lk(32'hBFC00010); tick();
    chk("alloc_taken", {31'd0, pr_taken}, 1);
    chk("alloc_target", pr_target, 32'hBFC00100);
    repeat (2) begin up(32'hBFC00010, 0, 0); tick(); end
    lk(32'hBFC00010); tick();
    chk("sat_low_taken", {31'd0, pr_taken}, 0);
    repeat (3) begin up(32'hBFC00010, 1, 32'hBFC00100); tick(); end
    up(32'hBFC00010, 0, 0); tick();
    lk(32'hBFC00010); tick();
    chk("sat_high_taken", {31'd0, pr_taken}, 1);
    up(32'h00000010, 1, 32'h0000AAA0); tick();
    up(32'h00000050, 1, 32'h0000BBB0); tick();
    lk(32'h00000010); tick();
    chk("alias_old_taken", {31'd0, pr_taken}, 0);
    chk("alias_old_target", pr_target, 0);
    lk(32'h00000050); tick();
    chk("alias_new_taken", {31'd0, pr_taken}, 1);
    chk("alias_new_target", pr_target, 32'h0000BBB0);
    lk(32'h00000200); up(32'h00000200, 1, 32'h00001234); tick();
    chk("simul_taken", {31'd0, pr_taken}, 0);
    chk("simul_target", pr_target, 0);
    lk(32'h00000200); tick();
    chk("simul_after", {31'd0, pr_taken}, 1);
    up(32'h00000300, 1, 32'h00005678); tick();
    flush_all = 1; up(32'h00000300, 1, 32'h00009999); lk(32'h00000300); tick();
    chk("preflush_target", pr_target, 32'h00005678);
    lk(32'h00000300); tick();
    chk("postflush_taken", {31'd0, pr_taken}, 0);
    chk("postflush_target", pr_target, 0);
    up(32'h00000400, 1, 32'h00004444); tick();
    lk(32'h00000400); tick();
    for (int i = 0; i < 3; i++) begin
      lk_stall = 1; lk_valid = 0; flush_all = (i == 0); up(32'h00000400, 1, 32'h00007777);
      tick();
      chk("stall_valid", {31'd0, pr_valid}, 1);
      chk("stall_taken", {31'd0, pr_taken}, 1);
      chk("stall_target", pr_target, 32'h00004444);
    end
    up(32'h00000400, 1, 32'h00004444); tick();
    lk(32'h00000400); tick();
    chk("prerst_taken", {31'd0, pr_taken}, 1);
    resetn = 0;
    #1;
    chk("midrst_valid", {31'd0, pr_valid}, 0);
    chk("midrst_target", pr_target, 0);
    tick();
    resetn = 1;
    lk(32'h00000400); tick();
    chk("postrst_taken", {31'd0, pr_taken}, 0);
    chk("postrst_target", pr_target, 0);
    for (int i = 0; i < 5; i++) begin
      up_valid = 1; up_mispredict = 1; tick();
    end
    chk("stat_five", stat_mispredicts, 5);
    for (int i = 0; i < 4000; i++) begin
      resetn = ($urandom_range(0, 499) != 0);
      lk_valid = $urandom_range(0, 1);
      lk_stall = ($urandom_range(0, 7) == 0);
      lk_pc = ($urandom_range(0, 1) ? 32'hBFC00000 : 32'h0) | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      up_valid = $urandom_range(0, 1);
      up_is_br = ($urandom_range(0, 3) != 0);
      up_taken = $urandom_range(0, 1);
      up_mispredict = $urandom_range(0, 1);
      up_pc = ($urandom_range(0, 1) ? 32'hBFC00000 : 32'h0) | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      up_target = $urandom;
      flush_all = ($urandom_range(0, 63) == 0);
      @(posedge clk);
      #2;
    end
    resetn = 1;
    tick();
    stat_forced = 1;
    force dut.stat_mispredicts = 32'hFFFFFFFF;
    #1;
    release dut.stat_mispredicts;
    for (int i = 0; i < 2; i++) begin
      up_valid = 1; up_mispredict = 1; tick();
      chk("stat_sat", stat_mispredicts, 32'hFFFFFFFF);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter IDX_W, default 4, giving BTB index width (2**IDX_W entries, direct-mapped).
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port resetn, input, 1, one clock; reset asynchronous and active-low.
REQ-004 The block SHALL have port lk_valid, input, 1, fetch presents a branch-candidate PC this cycle.
REQ-005 The block SHALL have port lk_pc, input, 32, virtual PC of the instruction being looked up.
REQ-006 The block SHALL have port lk_stall, input, 1, fetch stalled; hold prediction outputs.
REQ-007 The block SHALL have port pr_valid, output, 1, pr_taken/pr_target correspond to a lookup.
REQ-008 The block SHALL have port pr_taken, output, 1, predict_is_taken delivered down the pipe to execute.
REQ-009 The block SHALL have port pr_target, output, 32, predict_target delivered to execute.
REQ-010 The block SHALL have port up_valid, input, 1, execute-stage update valid (es_valid).
REQ-011 The block SHALL have port up_pc, input, 32, PC of the resolved branch/jump.
REQ-012 The block SHALL have port up_is_br, input, 1, resolved instruction has nonzero br_op.
REQ-013 The block SHALL have port up_taken, input, 1, resolved br_taken.
REQ-014 The block SHALL have port up_target, input, 32, resolved br_target.
REQ-015 The block SHALL have port up_mispredict, input, 1, inverse of execute predict_sucess.
REQ-016 The block SHALL have port flush_all, input, 1, invalidate every BTB entry (e.g. cache/TLB maintenance).
REQ-017 The block SHALL have port stat_mispredicts, output, 32, saturating mispredict counter.

Function
REQ-018 Index SHALL be pc[IDX_W+1:2]; tag SHALL be pc[31:IDX_W+2]; each entry holds valid, tag, 32-bit target, 2-bit saturating counter.
REQ-019 Lookup SHALL have one-cycle latency: at a clock edge with lk_stall=0, pr_valid<=lk_valid, pr_taken<=lk_valid & hit & ctr[1], pr_target<=hit ? entry target : 0.
REQ-020 Hit SHALL mean entry valid and stored tag equals lk_pc tag.
REQ-021 With lk_stall=1, pr_valid/pr_taken/pr_target SHALL hold their values regardless of lk_valid, updates or flush_all.
REQ-022 Update SHALL occur at the clock edge when up_valid & up_is_br; otherwise table unchanged.
REQ-023 Update hit, up_taken=1: ctr<=min(ctr+1,3), target<=up_target.
REQ-024 Update hit, up_taken=0: ctr<=max(ctr-1,0), target unchanged.
REQ-025 Update miss, up_taken=1: allocate (overwrite any occupant): valid<=1, tag, target<=up_target, ctr<=2'b10.
REQ-026 Update miss, up_taken=0: no change (no allocation).
REQ-027 Lookup and update in the same cycle to the same index SHALL return pre-update contents (no bypass).
REQ-028 flush_all SHALL clear all valid bits at the next edge, take priority over a same-cycle update, and same-cycle lookup SHALL see pre-flush contents.
REQ-029 stat_mispredicts SHALL increment by 1 at each edge with up_valid & up_mispredict, saturating at 0xFFFFFFFF (no wrap).
REQ-030 up_mispredict SHALL affect only stat_mispredicts, not table state.

Reset
REQ-031 While resetn=0, asynchronously: all valid bits 0, all counters 2'b01, pr_valid=0, pr_taken=0, pr_target=0, stat_mispredicts=0.
REQ-032 Reset asserted mid-operation SHALL discard pending lookup results; the first lookup after release SHALL miss.

Verification
REQ-033 Cold miss: after reset, lookup lk_pc=0xBFC00010 -> next cycle pr_valid=1, pr_taken=0, pr_target=0.
REQ-034 Allocate/hit: update pc=0xBFC00010 taken target=0xBFC00100, then lookup same pc -> pr_taken=1, pr_target=0xBFC00100.
REQ-035 Saturation: from allocate (ctr=10) apply two not-taken updates -> lookup pr_taken=0; three taken updates then -> ctr=11, one not-taken -> still pr_taken=1.
REQ-036 Alias: allocate 0x00000010, then taken update 0x00000050 (IDX_W=4, same index) -> lookup 0x00000010 misses, 0x00000050 hits target new.
REQ-037 Simultaneous/flush: lookup and allocating update same cycle -> pr_taken=0; flush_all with update same cycle -> subsequent lookup misses; lk_stall=1 holds pr_* for 3 cycles.
REQ-038 Stats: 5 cycles up_valid&up_mispredict -> stat_mispredicts=5; preload 0xFFFFFFFF via forced state -> further mispredict keeps 0xFFFFFFFF.
